opl2_write_scheduler: RTL and testbench

OPL2_WRITE_SCHEDULER -- requirements
Module: opl2_write_scheduler

---
 rtl/opl2_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/opl2_write_scheduler.sv | 132 +++++++++++++
 tb/tb_opl2_write_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/opl2_pkg.sv
// Shared constants for the OPL2 write scheduler: FSM encoding, register window offsets, default timing.
// Pure declarations; no latency, no backpressure.
`timescale 1ns/1ps
package opl2_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_AWAIT = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DWAIT = 3'd4;

    localparam logic [15:0] OFF_INDEX = 16'd0;
    localparam logic [15:0] OFF_DATA  = 16'd1;
    localparam logic [15:0] OFF_CTRL  = 16'd2;

    localparam int DEF_ADDR_WAIT = 27;
    localparam int DEF_DATA_WAIT = 185;
    localparam int DEF_DEPTH     = 16;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] dat;
    } entry_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, head visible combinationally one cycle after the push.
// Latency 1 cycle; push is refused when full unless a pop happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             phi2,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_dat,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers wrap naturally at DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge phi2) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_dat;
    end

    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
endmodule

// File: rtl/opl2_write_scheduler.sv
// Queues RIA register writes and replays them to the OPL2 core as paced index/data strobe pairs.
// First strobe 2 cycles after the data write; full FIFO drops new writes and sets sticky overflow.
`timescale 1ns/1ps
module opl2_write_scheduler
    import opl2_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'hFF00,
    parameter int          DEPTH     = DEF_DEPTH,
    parameter int          ADDR_WAIT = DEF_ADDR_WAIT,
    parameter int          DATA_WAIT = DEF_DATA_WAIT
) (
    input  logic        phi2,
    input  logic        rst,
    input  logic        msg_valid,
    input  logic [15:0] msg_addr,
    input  logic [7:0]  msg_data,
    output logic        opl_we,
    output logic        opl_a0,
    output logic [7:0]  opl_din,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);
    localparam int          WAIT_W   = $clog2(max_int(ADDR_WAIT, DATA_WAIT) + 1);
    localparam logic [15:0] A_INDEX  = BASE + OFF_INDEX;
    localparam logic [15:0] A_DATA   = BASE + OFF_DATA;
    localparam logic [15:0] A_CTRL   = BASE + OFF_CTRL;

    logic [2:0]        r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [7:0]        r_index;
    entry_t            r_entry;
    logic              r_overflow;

    entry_t w_head;
    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    logic   w_drop;
    logic   w_clear;

    assign w_push  = msg_valid && (msg_addr == A_DATA);
    assign w_clear = msg_valid && (msg_addr == A_CTRL) && msg_data[0];
    assign w_pop   = !w_empty && ((r_state == ST_IDLE) ||
                                  ((r_state == ST_DWAIT) && (r_wait == '0)));
    assign w_drop  = w_push && w_full && !w_pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .phi2     (phi2),
        .rst      (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_wr_dat ({r_index, msg_data}),
        .o_rd_dat (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            r_index    <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (msg_valid && (msg_addr == A_INDEX)) r_index <= msg_data;
            if (w_drop)       r_overflow <= 1'b1;
            else if (w_clear) r_overflow <= 1'b0;
        end
    end

    // The popped entry is held in r_entry so later index writes cannot disturb it.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
            r_entry <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_entry <= w_head;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_wait  <= WAIT_W'(ADDR_WAIT - 1);
                    r_state <= ST_AWAIT;
                end
                ST_AWAIT: begin
                    if (r_wait == '0) r_state <= ST_DATA;
                    else              r_wait  <= r_wait - 1'b1;
                end
                ST_DATA: begin
                    r_wait  <= WAIT_W'(DATA_WAIT - 1);
                    r_state <= ST_DWAIT;
                end
                ST_DWAIT: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - 1'b1;
                    end else if (w_pop) begin
                        r_entry <= w_head;
                        r_state <= ST_ADDR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        opl_we  = 1'b0;
        opl_a0  = 1'b0;
        opl_din = 8'h00;
        if (r_state == ST_ADDR) begin
            opl_we  = 1'b1;
            opl_din = r_entry.idx;
        end else if (r_state == ST_DATA) begin
            opl_we  = 1'b1;
            opl_a0  = 1'b1;
            opl_din = r_entry.dat;
        end
    end

    assign busy      = !w_empty || (r_state != ST_IDLE);
    assign fifo_full = w_full;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_opl2_write_scheduler.sv
// Scoreboard bench: stimulus queues expected OPL strobes, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_opl2_write_scheduler;
    logic        phi2 = 1'b0;
    logic        rst = 1'b0;
    logic        msg_valid = 1'b0;
    logic [15:0] msg_addr = 16'h0000;
    logic [7:0]  msg_data = 8'h00;
    logic        opl_we;
    logic        opl_a0;
    logic [7:0]  opl_din;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr = 0;
    int last_we = 0;
    int n_first = 0;

    // when: absolute cycle if is_abs, else gap in cycles since the previous strobe
    typedef struct {
        logic       a0;
        logic [7:0] din;
        int         when;
        bit         is_abs;
    } exp_t;
    exp_t q[$];

    opl2_write_scheduler #(
        .BASE      (16'hFF00),
        .DEPTH     (16),
        .ADDR_WAIT (27),
        .DATA_WAIT (185)
    ) dut (
        .phi2      (phi2),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_addr  (msg_addr),
        .msg_data  (msg_data),
        .opl_we    (opl_we),
        .opl_a0    (opl_a0),
        .opl_din   (opl_din),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 phi2 = ~phi2;
    always @(posedge phi2) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge phi2);
            if (opl_we === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_we_queue_depth", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk("we_a0", int'(opl_a0), int'(e.a0));
                    chk("we_din", int'(opl_din), int'(e.din));
                    if (e.is_abs) chk("we_start_cycle", cyc, e.when);
                    else          chk("we_gap", cyc - last_we, e.when);
                end
                last_we = cyc;
            end
        end
    end

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge phi2);
        msg_valid = 1'b1;
        msg_addr  = a;
        msg_data  = d;
        @(posedge phi2);
        #1;
        last_wr   = cyc;
        msg_valid = 1'b0;
    endtask

    // Pair timing: 28 cycles index->data (27 idle between), 186 data->next index, 214 pitch.
    task automatic wr_dat(input logic [7:0] idx, input logic [7:0] d, input bit first);
        wr(16'hFF01, d);
        q.push_back('{a0: 1'b0, din: idx, when: (first ? last_wr + 1 : 186), is_abs: first});
        q.push_back('{a0: 1'b1, din: d, when: 28, is_abs: 1'b0});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((busy || q.size() != 0) && n < budget) begin
            @(posedge phi2);
            n++;
        end
        chk({name, "_drain_in_budget"}, int'(n < budget), 1);
        @(negedge phi2);
        chk({name, "_busy_idle"}, int'(busy), 0);
        chk({name, "_queue_empty"}, q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_we"}, int'(opl_we), 0);
        chk({name, "_a0"}, int'(opl_a0), 0);
        chk({name, "_din"}, int'(opl_din), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_full"}, int'(fifo_full), 0);
        chk({name, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge phi2);
        #1;
        chk_reset_outputs("reset");
        @(negedge phi2);
        rst = 1'b0;

        // Out-of-window writes: no strobe, no push, index stays 00.
        wr(16'hFF03, 8'h55);
        wr(16'h0000, 8'h66);
        repeat (3) @(negedge phi2);
        chk("ignored_busy", int'(busy), 0);
        wr_dat(8'h00, 8'h77, 1'b1);
        drain("ignored", 400);

        wr(16'hFF00, 8'h20);
        wr_dat(8'h20, 8'h01, 1'b1);
        drain("single", 400);

        // Index changes while the first entry is in flight must not leak into it.
        wr(16'hFF00, 8'hA0);
        wr_dat(8'hA0, 8'h44, 1'b1);
        wr(16'hFF00, 8'hB0);
        wr_dat(8'hB0, 8'h32, 1'b0);
        wr_dat(8'hB0, 8'h12, 1'b0);
        drain("burst", 1000);

        wr(16'hFF00, 8'h40);
        wr_dat(8'h40, 8'hE0, 1'b1);
        n_first = last_wr;
        for (int i = 0; i < 16; i++) wr_dat(8'h40, 8'(i), 1'b0);
        chk("fill_full", int'(fifo_full), 1);
        chk("fill_no_overflow", int'(overflow), 0);
        wr(16'hFF01, 8'h99);
        chk("drop_full", int'(fifo_full), 1);
        chk("drop_overflow", int'(overflow), 1);
        wr(16'hFF02, 8'h00);
        chk("ctrl_bit0_zero_keeps", int'(overflow), 1);
        wr(16'hFF02, 8'h01);
        chk("ctrl_clear", int'(overflow), 0);
        wr(16'hFF01, 8'h98);
        chk("drop_again_overflow", int'(overflow), 1);
        // Push lands on the same edge as the DWAIT pop of the first entry.
        while (cyc < n_first + 214) begin
            @(posedge phi2);
            #1;
        end
        wr_dat(8'h40, 8'hD5, 1'b0);
        chk("push_pop_full", int'(fifo_full), 1);
        chk("push_pop_overflow", int'(overflow), 1);
        drain("overflow", 5000);

        wr(16'hFF00, 8'h11);
        wr(16'hFF01, 8'h22);
        q.push_back('{a0: 1'b0, din: 8'h11, when: last_wr + 1, is_abs: 1'b1});
        repeat (10) @(posedge phi2);
        #3 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge phi2);
        rst = 1'b0;
        repeat (60) @(negedge phi2);
        chk("midrst_after_busy", int'(busy), 0);
        chk("midrst_no_pending", q.size(), 0);
        wr_dat(8'h00, 8'h33, 1'b1);
        drain("post_reset", 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
